// File: rtl/fitness_pkg.sv
// Shared types and constants for the fitness scheduler timing blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fitness_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int T_W         = 9;
  localparam int SEC_W       = 6;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICKS_PER_SEC enabled cycles.
// Latency: tick is combinational from the count register and the enable.
// Backpressure: count holds while en is low; clr restarts the second from zero.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // Count enabled cycles, wrapping at the terminal count; hold when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/session_timer.sv
// Workout countdown timer: loads minutes, counts down min:sec with start/pause/abort.
// Latency: all outputs registered; load/start/pause/abort take effect at the next edge.
// Backpressure: t_ready low in RUN/PAUSE; offered loads are ignored until IDLE or DONE.
module session_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int T_W           = fitness_pkg::T_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         t_valid,
  input  logic [T_W-1:0]               t_min,
  output logic                         t_ready,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         abort,
  output logic [T_W-1:0]               rem_min,
  output logic [fitness_pkg::SEC_W-1:0] rem_sec,
  output logic                         busy,
  output logic                         paused,
  output logic                         done,
  output logic [1:0]                   state
);

  import fitness_pkg::*;

  timer_state_t     state_q, state_d;
  logic [T_W-1:0]   min_d;
  logic [SEC_W-1:0] sec_d;
  logic             loaded, loaded_d;
  logic             done_d;
  logic             presc_en, presc_clr;
  logic             tick;

  // Prescaler only advances in RUN, and a same-cycle pause or abort steals the cycle.
  assign presc_en = (state_q == RUN) && !pause && !abort;
  assign t_ready  = (state_q == IDLE) || (state_q == DONE);
  assign state    = state_q;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Next-state, countdown arithmetic and done pulse; abort outranks pause outranks tick.
  always_comb begin
    state_d   = state_q;
    min_d     = rem_min;
    sec_d     = rem_sec;
    loaded_d  = loaded;
    done_d    = 1'b0;
    presc_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A load in the same cycle wins over start; start sees the committed value later.
        if (t_valid) begin
          min_d    = t_min;
          sec_d    = '0;
          loaded_d = 1'b1;
        end else if (start && loaded) begin
          if (rem_min != '0) begin
            state_d   = RUN;
            presc_clr = 1'b1;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            loaded_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          min_d     = '0;
          sec_d     = '0;
          loaded_d  = 1'b0;
          presc_clr = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (rem_sec == '0) begin
            sec_d = SEC_W'(SEC_PER_MIN - 1);
            min_d = rem_min - 1'b1;
          end else begin
            sec_d = rem_sec - 1'b1;
          end
          // 0:01 is the only value whose decrement lands on 0:00.
          if (rem_min == '0 && rem_sec == SEC_W'(1)) begin
            state_d  = DONE;
            done_d   = 1'b1;
            loaded_d = 1'b0;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_d   = IDLE;
          min_d     = '0;
          sec_d     = '0;
          loaded_d  = 1'b0;
          presc_clr = 1'b1;
        end else if (pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (t_valid) begin
          state_d  = IDLE;
          min_d    = t_min;
          sec_d    = '0;
          loaded_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, remaining time and status flags all register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_min <= '0;
      rem_sec <= '0;
      loaded  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      paused  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_min <= min_d;
      rem_sec <= sec_d;
      loaded  <= loaded_d;
      done    <= done_d;
      busy    <= (state_d == RUN) || (state_d == PAUSE);
      paused  <= (state_d == PAUSE);
    end
  end

endmodule

// File: tb/tb_session_timer.sv
// Directed checks of session_timer with a 4-cycle second.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_session_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t_valid = 1'b0;
  logic [8:0] t_min = '0;
  logic       t_ready;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] rem_min;
  logic [5:0] rem_sec;
  logic       busy, paused, done;
  logic [1:0] state;

  int vec  = 0;
  int errs = 0;

  session_timer #(.TICKS_PER_SEC(4), .T_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .t_valid(t_valid), .t_min(t_min), .t_ready(t_ready),
    .start(start), .pause(pause), .abort(abort), .rem_min(rem_min), .rem_sec(rem_sec),
    .busy(busy), .paused(paused), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs changed afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [8:0] m);
    t_valid = 1'b1; t_min = m;
    tick();
    t_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vec++; if (state !== 2'd0 || t_ready !== 1'b1) begin errs++; $display("FAIL reset_in state=%0d t_ready=%0b want 0/1", state, t_ready); end
    rst_n = 1'b1;
    tick();
    vec++; if (state !== 2'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state); end
    vec++; if (t_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %0b want 1", t_ready); end
    vec++; if (rem_min !== 9'd0 || rem_sec !== 6'd0) begin errs++; $display("FAIL reset_rem got %0d:%0d want 0:0", rem_min, rem_sec); end
    vec++; if ({busy, paused, done} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {busy, paused, done}); end
    do_start();
    vec++; if (state !== 2'd0 || busy !== 1'b0) begin errs++; $display("FAIL start_unloaded state=%0d busy=%0b want 0/0", state, busy); end
  endtask

  task automatic test_full_run();
    int n;
    do_load(9'd2);
    vec++; if (rem_min !== 9'd2 || rem_sec !== 6'd0) begin errs++; $display("FAIL load_rem got %0d:%0d want 2:0", rem_min, rem_sec); end
    do_start();
    vec++; if (state !== 2'd1 || busy !== 1'b1 || t_ready !== 1'b0) begin errs++; $display("FAIL run_entry state=%0d busy=%0b rdy=%0b want 1/1/0", state, busy, t_ready); end
    tick(); tick(); tick();
    vec++; if (rem_min !== 9'd2 || rem_sec !== 6'd0) begin errs++; $display("FAIL pre_first_dec got %0d:%0d want 2:0", rem_min, rem_sec); end
    tick();
    vec++; if (rem_min !== 9'd1 || rem_sec !== 6'd59) begin errs++; $display("FAIL first_dec got %0d:%0d want 1:59", rem_min, rem_sec); end
    n = 4;
    while (n < 700 && done !== 1'b1) begin tick(); n++; end
    vec++; if (n !== 480) begin errs++; $display("FAIL done_time got %0d want 480", n); end
    vec++; if (rem_min !== 9'd0 || rem_sec !== 6'd0 || state !== 2'd3 || t_ready !== 1'b1) begin
      errs++; $display("FAIL done_outputs got %0d:%0d st=%0d rdy=%0b want 0:0 st=3 rdy=1", rem_min, rem_sec, state, t_ready); end
    tick();
    vec++; if (done !== 1'b0 || state !== 2'd3) begin errs++; $display("FAIL done_pulse got done=%0b st=%0d want 0/3", done, state); end
  endtask

  task automatic test_pause();
    int n;
    int held_bad;
    do_load(9'd2);
    vec++; if (state !== 2'd0) begin errs++; $display("FAIL load_from_done got %0d want 0", state); end
    do_start();
    for (int i = 0; i < 120; i++) tick();
    vec++; if (rem_min !== 9'd1 || rem_sec !== 6'd30) begin errs++; $display("FAIL at_1_30 got %0d:%0d want 1:30", rem_min, rem_sec); end
    pause = 1'b1; tick(); pause = 1'b0;
    vec++; if (state !== 2'd2 || paused !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL pause_entry st=%0d paused=%0b busy=%0b want 2/1/1", state, paused, busy); end
    held_bad = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (rem_min !== 9'd1 || rem_sec !== 6'd30 || paused !== 1'b1) held_bad++;
    end
    vec++; if (held_bad !== 0) begin errs++; $display("FAIL pause_hold bad_cycles=%0d want 0", held_bad); end
    pause = 1'b1; tick(); pause = 1'b0;
    vec++; if (state !== 2'd1 || paused !== 1'b0) begin errs++; $display("FAIL resume st=%0d paused=%0b want 1/0", state, paused); end
    n = 221;
    while (n < 900 && done !== 1'b1) begin tick(); n++; end
    vec++; if (n !== 581) begin errs++; $display("FAIL pause_done_time got %0d want 581", n); end
  endtask

  task automatic test_zero_load();
    do_load(9'd0);
    do_start();
    vec++; if (state !== 2'd3 || done !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL zero_start st=%0d done=%0b busy=%0b want 3/1/0", state, done, busy); end
    tick();
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL zero_done_pulse got %0b want 0", done); end
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    do_load(9'd3);
    do_start();
    for (int i = 0; i < 100; i++) tick();
    vec++; if (t_ready !== 1'b0) begin errs++; $display("FAIL ready_in_run got %0b want 0", t_ready); end
    t_valid = 1'b1; t_min = 9'd7; tick(); t_valid = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    vec++; if (rem_min !== 9'd2 || rem_sec !== 6'd10 || state !== 2'd1) begin errs++; $display("FAIL at_2_10 got %0d:%0d st=%0d want 2:10 st=1", rem_min, rem_sec, state); end
    abort = 1'b1; tick(); abort = 1'b0;
    if (done === 1'b1) done_seen++;
    vec++; if (state !== 2'd0 || rem_min !== 9'd0 || rem_sec !== 6'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL abort got st=%0d %0d:%0d busy=%0b want 0 0:0 0", state, rem_min, rem_sec, busy); end
    do_start();
    if (done === 1'b1) done_seen++;
    vec++; if (state !== 2'd0) begin errs++; $display("FAIL start_after_abort got %0d want 0", state); end
    for (int i = 0; i < 8; i++) begin tick(); if (done === 1'b1) done_seen++; end
    vec++; if (done_seen !== 0) begin errs++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
  endtask

  task automatic test_async_reset();
    int done_seen;
    done_seen = 0;
    do_load(9'd1);
    do_start();
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    vec++; if (state !== 2'd0 || t_ready !== 1'b1 || rem_min !== 9'd0 || rem_sec !== 6'd0 || {busy, paused, done} !== 3'b000) begin
      errs++; $display("FAIL async_reset st=%0d rdy=%0b %0d:%0d flags=%b want 0 1 0:0 000", state, t_ready, rem_min, rem_sec, {busy, paused, done}); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin tick(); if (done === 1'b1) done_seen++; end
    vec++; if (done_seen !== 0 || state !== 2'd0) begin errs++; $display("FAIL post_reset done=%0d st=%0d want 0/0", done_seen, state); end
  endtask

  task automatic test_abort_pause_same();
    do_load(9'd1);
    do_start();
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1; pause = 1'b1; tick(); abort = 1'b0; pause = 1'b0;
    vec++; if (state !== 2'd0 || paused !== 1'b0 || rem_min !== 9'd0 || rem_sec !== 6'd0) begin
      errs++; $display("FAIL abort_pause st=%0d paused=%0b %0d:%0d want 0 0 0:0", state, paused, rem_min, rem_sec); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_pause();
    test_zero_load();
    test_abort();
    test_async_reset();
    test_abort_pause_same();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
